// File: rtl/seq_const_compare.sv
// seq_const_compare: registered, run-time programmable sample comparator.
// Compares valid-qualified samples against a loadable reference using a
// selectable relation (EQ/NE/LT/GT), counts matches (saturating) and flags
// runs of RUN_LEN consecutive matches.
// Optional build macro SEQ_CMP_SIGNED_EN: LT/GT treat num and the reference
// as two's-complement WIDTH-bit values; otherwise they are unsigned.
module seq_const_compare #(
    parameter int WIDTH    = 4,
    parameter int REF_INIT = 3,
    parameter int CNT_W    = 8,
    parameter int RUN_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ref_we,
    input  logic [WIDTH-1:0] ref_in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] num,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             eq,
    output logic             hit,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [WIDTH-1:0] REF_RST = WIDTH'(REF_INIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RUN_TGT = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    logic [WIDTH-1:0] ref_reg;
    logic             match;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;

    // Reference register; a sample in the same cycle as a load still sees the old value.
    always_ff @(posedge clk) begin
        if (rst)
            ref_reg <= REF_RST;
        else if (ref_we)
            ref_reg <= ref_in;
    end

    // Relation between the current sample and the reference, selected by mode.
    always_comb begin
        match = 1'b0;
        case (mode)
            2'b00: match = (num == ref_reg);
            2'b01: match = (num != ref_reg);
`ifdef SEQ_CMP_SIGNED_EN
            2'b10: match = ($signed(num) < $signed(ref_reg));
            2'b11: match = ($signed(num) > $signed(ref_reg));
`else
            2'b10: match = (num < ref_reg);
            2'b11: match = (num > ref_reg);
`endif
        endcase
    end

    // Per-sample result: out_valid follows in_valid, eq holds across gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                eq <= match;
        end
    end

    // Saturating match counter; clear wins over a simultaneous match.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            match_cnt <= '0;
        else if (in_valid && match && (match_cnt != CNT_MAX))
            match_cnt <= match_cnt + ONE;
    end

    // Run FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Run FSM next state: only valid samples advance it; any valid mismatch drops the run.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        run_d   = ONE;
                        state_d = (RUN_LEN == 1) ? HIT : RUN;
                    end
                end
                RUN: begin
                    if (match) begin
                        run_d = run_q + ONE;
                        if (run_q + ONE == RUN_TGT)
                            state_d = HIT;
                    end else begin
                        run_d   = '0;
                        state_d = IDLE;
                    end
                end
                HIT: begin
                    // Run length is frozen once the hit threshold is reached.
                    if (!match) begin
                        run_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    run_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State is registered, so hit lines up with eq of the completing sample.
    assign hit = (state_q == HIT);

endmodule

// File: tb/tb_seq_const_compare.sv
// Bench for seq_const_compare: directed vector table, a saturation sequence
// on a narrow-counter instance, and randomized traffic against a streak model.
module tb_seq_const_compare;

`ifdef SEQ_CMP_SIGNED_EN
    localparam int SG = 1;
`else
    localparam int SG = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, ref_we, in_valid, cnt_clr;
    logic [3:0] ref_in, num;
    logic [1:0] mode;
    logic       ov1, eq1, hit1, ov2, eq2, hit2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    seq_const_compare #(.WIDTH(4), .REF_INIT(3), .CNT_W(8), .RUN_LEN(3)) dut (
        .clk(clk), .rst(rst), .ref_we(ref_we), .ref_in(ref_in), .mode(mode),
        .in_valid(in_valid), .num(num), .cnt_clr(cnt_clr),
        .out_valid(ov1), .eq(eq1), .hit(hit1), .match_cnt(cnt1));

    seq_const_compare #(.WIDTH(4), .REF_INIT(3), .CNT_W(2), .RUN_LEN(1)) dut2 (
        .clk(clk), .rst(rst), .ref_we(ref_we), .ref_in(ref_in), .mode(mode),
        .in_valid(in_valid), .num(num), .cnt_clr(cnt_clr),
        .out_valid(ov2), .eq(eq2), .hit(hit2), .match_cnt(cnt2));

    int nvec = 0;
    int nerr = 0;

    // Reference model: state after the most recent edge.
    int mref = 3, mov = 0, meq = 0, mstreak = 0, mcnt1 = 0, mcnt2 = 0;

    typedef struct {
        bit r, we; int ri, md; bit v; int n; bit c;
        int ov, eq, hit, cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit r, bit we, int ri, int md, bit v, int n, bit c,
                                int ov, int e, int h, int cnt);
        vec_t t;
        t.r = r; t.we = we; t.ri = ri; t.md = md; t.v = v; t.n = n; t.c = c;
        t.ov = ov; t.eq = e; t.hit = h; t.cnt = cnt;
        tbl.push_back(t);
    endfunction

    function automatic bit rel(int md, int n, int r);
        int a = n, b = r;
        if (SG == 1) begin
            if (a >= 8) a -= 16;
            if (b >= 8) b -= 16;
        end
        case (md)
            0: return a == b;
            1: return a != b;
            2: return a < b;
            default: return a > b;
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(bit r, bit we, int ri, int md, bit v, int n, bit c);
        bit m;
        rst = r; ref_we = we; ref_in = ri[3:0]; mode = md[1:0];
        in_valid = v; num = n[3:0]; cnt_clr = c;
        if (r) begin
            mref = 3; mov = 0; meq = 0; mstreak = 0; mcnt1 = 0; mcnt2 = 0;
        end else begin
            m = rel(md, n, mref);
            if (we) mref = ri;
            mov = v;
            if (v) begin
                meq = m;
                mstreak = m ? mstreak + 1 : 0;
            end
            if (c) begin
                mcnt1 = 0; mcnt2 = 0;
            end else if (v && m) begin
                if (mcnt1 < 255) mcnt1++;
                if (mcnt2 < 3) mcnt2++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(string tag, bit both);
        if (both) begin
            chk({tag, ".ov1"}, ov1, mov);
            chk({tag, ".eq1"}, eq1, meq);
            chk({tag, ".hit1"}, hit1, (mstreak >= 3) ? 1 : 0);
            chk({tag, ".cnt1"}, cnt1, mcnt1);
        end
        chk({tag, ".ov2"}, ov2, mov);
        chk({tag, ".eq2"}, eq2, meq);
        chk({tag, ".hit2"}, hit2, (mstreak >= 1) ? 1 : 0);
        chk({tag, ".cnt2"}, cnt2, mcnt2);
    endtask

    initial begin
        rst = 1'b0; ref_we = 1'b0; ref_in = '0; mode = '0;
        in_valid = 1'b0; num = '0; cnt_clr = 1'b0;

        // Reset, then EQ sweep against the reset reference 3.
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        for (int n = 0; n < 16; n++)
            add(0, 0, 0, 0, 1, n, 0,  1, (n == 3) ? 1 : 0, 0, (n >= 3) ? 1 : 0);
        // Reference load in the same cycle as a sample: old ref applies.
        add(0, 1, 9, 0, 1, 3, 0,  1, 1, 0, 2);
        add(0, 0, 0, 0, 1, 9, 0,  1, 1, 0, 3);
        // Run detection with ref 5: 5,5,7,5,5,5,5.
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 5, 0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 5, 0,  1, 1, 0, 1);
        add(0, 0, 0, 0, 1, 5, 0,  1, 1, 0, 2);
        add(0, 0, 0, 0, 1, 7, 0,  1, 0, 0, 2);
        add(0, 0, 0, 0, 1, 5, 0,  1, 1, 0, 3);
        add(0, 0, 0, 0, 1, 5, 0,  1, 1, 0, 4);
        add(0, 0, 0, 0, 1, 5, 0,  1, 1, 1, 5);
        add(0, 0, 0, 0, 1, 5, 0,  1, 1, 1, 6);
        add(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 6);   // gap holds everything
        add(0, 0, 0, 0, 1, 6, 0,  1, 0, 0, 6);
        // LT against ref 4 with a top-bit sample; GT on equality.
        add(0, 1, 4, 0, 0, 0, 0,  0, 0, 0, 6);
        add(0, 0, 0, 2, 1, 12, 0, 1, SG, 0, 6 + SG);
        add(0, 0, 0, 3, 1, 4, 0,  1, 0, 0, 6 + SG);
        // Run built across a gap and a mode change, then clear with a match.
        add(0, 0, 0, 0, 1, 4, 0,  1, 1, 0, 7 + SG);
        add(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 7 + SG);
        add(0, 0, 0, 0, 1, 4, 0,  1, 1, 0, 8 + SG);
        add(0, 0, 0, 1, 1, 7, 0,  1, 1, 1, 9 + SG);
        add(0, 0, 0, 0, 1, 4, 1,  1, 1, 1, 0);
        // Reset while in HIT restores ref 3.
        add(1, 0, 0, 0, 1, 4, 0,  0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0,  1, 1, 0, 1);
        add(0, 0, 0, 2, 1, 2, 0,  1, 1, 0, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].we, tbl[i].ri, tbl[i].md, tbl[i].v, tbl[i].n, tbl[i].c);
            chk($sformatf("vec%0d.ov", i), ov1, tbl[i].ov);
            chk($sformatf("vec%0d.eq", i), eq1, tbl[i].eq);
            chk($sformatf("vec%0d.hit", i), hit1, tbl[i].hit);
            chk($sformatf("vec%0d.cnt", i), cnt1, tbl[i].cnt);
            chk_model($sformatf("vec%0d", i), 1'b0);
        end

        // Narrow counter saturates at 3; RUN_LEN=1 hits on the first match.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 0, 1, 3, 0);
            chk($sformatf("sat%0d.cnt2", k), cnt2, (k < 3) ? k : 3);
            chk($sformatf("sat%0d.hit2", k), hit2, 1);
            chk($sformatf("sat%0d.cnt1", k), cnt1, k);
        end
        step(0, 0, 0, 0, 1, 3, 1);
        chk("satclr.cnt2", cnt2, 0);
        chk("satclr.cnt1", cnt1, 0);
        chk("satclr.hit1", hit1, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            bit r, we, v, c;
            int ri, md, n;
            r  = ($urandom_range(49, 0) == 0);
            we = ($urandom_range(7, 0) == 0);
            ri = $urandom_range(15, 0);
            md = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3, 0);
            v  = ($urandom_range(3, 0) != 0);
            n  = ($urandom_range(1, 0) == 0) ? mref : $urandom_range(15, 0);
            c  = ($urandom_range(29, 0) == 0);
            step(r, we, ri, md, v, n, c);
            chk_model($sformatf("rnd%0d", i), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
